// File: rtl/regfile_context_stack.sv
// regfile_context_stack: LIFO of saved register-file contexts feeding the
// stacked register file's command, push-data and pop-data inputs.
module regfile_context_stack #(
    parameter  int unsigned NREGS = 32,
    parameter  int unsigned WIDTH = 32,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned DW    = $clog2(DEPTH + 1)
) (
    input  logic                              i_clk,
    input  logic                              i_reset,
    input  logic                              i_push_req,
    input  logic                              i_pop_req,
    input  logic                              i_clear_err,
    input  logic [NREGS-1:0][WIDTH-1:0]       i_save_data,
    input  logic [NREGS-1:0][WIDTH-1:0]       i_entry_data,
    output logic [1:0]                        o_command,
    output logic [NREGS-1:0][WIDTH-1:0]       o_push_data,
    output logic [NREGS-1:0][WIDTH-1:0]       o_pop_data,
    output logic                              o_ack,
    output logic [DW-1:0]                     o_depth,
    output logic                              o_full,
    output logic                              o_empty,
    output logic                              o_overflow,
    output logic                              o_underflow
);

    typedef enum logic [1:0] {
        CMD_NONE = 2'd0,
        CMD_PUSH = 2'd1,
        CMD_POP  = 2'd2
    } cmd_e;

    localparam logic [DW-1:0] SP_MAX = DW'(DEPTH);

    logic [NREGS-1:0][WIDTH-1:0] r_mem [DEPTH];
    logic [DW-1:0]               r_sp;
    logic                        r_overflow;
    logic                        r_underflow;

    cmd_e                        w_command;
    logic                        w_ack;
    logic                        w_push_accept;
    logic                        w_pop_accept;
    logic                        w_ovf_set;
    logic                        w_unf_set;
    logic                        w_push;
    logic                        w_pop;
    logic                        w_full;
    logic                        w_empty;
    logic [NREGS-1:0][WIDTH-1:0] w_pop_data;

    // Requests are masked while reset is held so nothing reaches the register file.
    assign w_push  = i_push_req & ~i_reset;
    assign w_pop   = i_pop_req  & ~i_reset;
    assign w_full  = (r_sp == SP_MAX);
    assign w_empty = (r_sp == '0);

    // Prioritised request decode; a simultaneous push+pop is a tail-chain that
    // only reloads the fresh context and leaves the saved frames untouched.
    always_comb begin
        w_command     = CMD_NONE;
        w_ack         = 1'b0;
        w_push_accept = 1'b0;
        w_pop_accept  = 1'b0;
        w_ovf_set     = 1'b0;
        w_unf_set     = 1'b0;
        if (w_push && w_pop) begin
            w_command = CMD_PUSH;
            w_ack     = 1'b1;
        end else if (w_push) begin
            if (!w_full) begin
                w_command     = CMD_PUSH;
                w_ack         = 1'b1;
                w_push_accept = 1'b1;
            end else begin
                w_ovf_set = 1'b1;
            end
        end else if (w_pop) begin
            if (!w_empty) begin
                w_command    = CMD_POP;
                w_ack        = 1'b1;
                w_pop_accept = 1'b1;
            end else begin
                w_unf_set = 1'b1;
            end
        end
    end

    // Top-of-stack read: frame sp-1, or zeros when nothing is saved.
    always_comb begin
        w_pop_data = '0;
        for (int d = 0; d < int'(DEPTH); d++) begin
            if (r_sp == DW'(d + 1)) begin
                w_pop_data = r_mem[d];
            end
        end
    end

    // Stack pointer moves by one on an accepted push or pop.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_sp <= '0;
        end else if (w_push_accept) begin
            r_sp <= r_sp + DW'(1);
        end else if (w_pop_accept) begin
            r_sp <= r_sp - DW'(1);
        end
    end

    // Frame memory: only slot sp is written, and only on an accepted push.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int d = 0; d < int'(DEPTH); d++) begin
                r_mem[d] <= '0;
            end
        end else begin
            for (int d = 0; d < int'(DEPTH); d++) begin
                if (w_push_accept && (r_sp == DW'(d))) begin
                    r_mem[d] <= i_save_data;
                end
            end
        end
    end

    // Sticky error flags; a new error in the clearing cycle keeps the flag set.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= (r_overflow  & ~i_clear_err) | w_ovf_set;
            r_underflow <= (r_underflow & ~i_clear_err) | w_unf_set;
        end
    end

    assign o_command   = w_command;
    assign o_ack       = w_ack;
    assign o_push_data = i_entry_data;
    assign o_pop_data  = w_pop_data;
    assign o_depth     = r_sp;
    assign o_full      = w_full;
    assign o_empty     = w_empty;
    assign o_overflow  = r_overflow;
    assign o_underflow = r_underflow;

endmodule

// File: tb/tb_regfile_context_stack.sv
// Bench for regfile_context_stack: directed scenarios then random traffic,
// all checked against a queue-based model of the saved-context stack.
module tb_regfile_context_stack;

    localparam int unsigned NREGS = 4;
    localparam int unsigned WIDTH = 16;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned DW    = $clog2(DEPTH + 1);

    localparam logic [1:0] C_NONE = 2'd0;
    localparam logic [1:0] C_PUSH = 2'd1;
    localparam logic [1:0] C_POP  = 2'd2;

    typedef logic [NREGS-1:0][WIDTH-1:0] frame_t;

    logic          clk;
    logic          i_reset;
    logic          i_push_req;
    logic          i_pop_req;
    logic          i_clear_err;
    frame_t        i_save_data;
    frame_t        i_entry_data;
    logic [1:0]    o_command;
    frame_t        o_push_data;
    frame_t        o_pop_data;
    logic          o_ack;
    logic [DW-1:0] o_depth;
    logic          o_full;
    logic          o_empty;
    logic          o_overflow;
    logic          o_underflow;

    regfile_context_stack #(
        .NREGS (NREGS),
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .i_clk        (clk),
        .i_reset      (i_reset),
        .i_push_req   (i_push_req),
        .i_pop_req    (i_pop_req),
        .i_clear_err  (i_clear_err),
        .i_save_data  (i_save_data),
        .i_entry_data (i_entry_data),
        .o_command    (o_command),
        .o_push_data  (o_push_data),
        .o_pop_data   (o_pop_data),
        .o_ack        (o_ack),
        .o_depth      (o_depth),
        .o_full       (o_full),
        .o_empty      (o_empty),
        .o_overflow   (o_overflow),
        .o_underflow  (o_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: saved frames as a queue (back = most recent) plus flags.
    frame_t m_stack[$];
    logic   m_ovf;
    logic   m_unf;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic frame_t mk(input int unsigned a0, input int unsigned a1);
        frame_t f;
        f = '0;
        f[0] = WIDTH'(a0);
        f[1] = WIDTH'(a1);
        return f;
    endfunction

    function automatic frame_t rnd_frame();
        frame_t f;
        for (int r = 0; r < int'(NREGS); r++) f[r] = WIDTH'($urandom);
        return f;
    endfunction

    task automatic check_state(input string ctx);
        int d;
        frame_t top;
        d = m_stack.size();
        top = (d > 0) ? m_stack[d-1] : '0;
        check({ctx, ".depth"},     128'(o_depth),     128'(d));
        check({ctx, ".full"},      128'(o_full),      128'(d == int'(DEPTH)));
        check({ctx, ".empty"},     128'(o_empty),     128'(d == 0));
        check({ctx, ".pop_data"},  128'(o_pop_data),  128'(top));
        check({ctx, ".overflow"},  128'(o_overflow),  128'(m_ovf));
        check({ctx, ".underflow"}, 128'(o_underflow), 128'(m_unf));
    endtask

    // One clock cycle: drive at negedge, check combinational outputs, then
    // advance the model across the rising edge.
    task automatic step(input string ctx, input logic push, input logic pop, input logic clr,
                        input frame_t save, input frame_t entry);
        logic [1:0] ecmd;
        logic       eack, pacc, oacc, oset, uset;
        int         d;
        @(negedge clk);
        i_push_req   = push;
        i_pop_req    = pop;
        i_clear_err  = clr;
        i_save_data  = save;
        i_entry_data = entry;
        #1;
        d = m_stack.size();
        ecmd = C_NONE; eack = 1'b0; pacc = 1'b0; oacc = 1'b0; oset = 1'b0; uset = 1'b0;
        if (push && pop) begin
            ecmd = C_PUSH; eack = 1'b1;
        end else if (push) begin
            if (d < int'(DEPTH)) begin ecmd = C_PUSH; eack = 1'b1; pacc = 1'b1; end
            else oset = 1'b1;
        end else if (pop) begin
            if (d > 0) begin ecmd = C_POP; eack = 1'b1; oacc = 1'b1; end
            else uset = 1'b1;
        end
        check({ctx, ".command"},   128'(o_command),   128'(ecmd));
        check({ctx, ".ack"},       128'(o_ack),       128'(eack));
        check({ctx, ".push_data"}, 128'(o_push_data), 128'(entry));
        check_state(ctx);
        @(posedge clk);
        if (pacc) m_stack.push_back(save);
        if (oacc) void'(m_stack.pop_back());
        m_ovf = (m_ovf && !clr) || oset;
        m_unf = (m_unf && !clr) || uset;
    endtask

    task automatic idle(input string ctx);
        step(ctx, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic apply_reset(input string ctx);
        frame_t e;
        e = rnd_frame();
        @(negedge clk);
        i_reset      = 1'b1;
        i_push_req   = 1'b1;
        i_pop_req    = 1'b0;
        i_clear_err  = 1'b0;
        i_save_data  = rnd_frame();
        i_entry_data = e;
        @(posedge clk);
        #1;
        m_stack.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        check({ctx, ".command"},   128'(o_command),   128'(C_NONE));
        check({ctx, ".ack"},       128'(o_ack),       128'(0));
        check({ctx, ".push_data"}, 128'(o_push_data), 128'(e));
        check_state(ctx);
        @(negedge clk);
        i_reset    = 1'b0;
        i_push_req = 1'b0;
    endtask

    initial begin
        i_reset      = 1'b1;
        i_push_req   = 1'b0;
        i_pop_req    = 1'b0;
        i_clear_err  = 1'b0;
        i_save_data  = '0;
        i_entry_data = '0;
        m_ovf        = 1'b0;
        m_unf        = 1'b0;

        // Reset state
        apply_reset("reset");

        // Single push, then confirm captured frame on the pop port
        step("push1", 1'b1, 1'b0, 1'b0, mk(7, 8), mk(1, 2));
        idle("push1_after");
        check("push1.pop0", 128'(o_pop_data[0]), 128'(7));
        check("push1.pop1", 128'(o_pop_data[1]), 128'(8));

        // Nested push/pop
        apply_reset("reset_nest");
        step("nest_push_a", 1'b1, 1'b0, 1'b0, mk(7, 0), mk(3, 3));
        step("nest_push_b", 1'b1, 1'b0, 1'b0, mk(9, 0), mk(4, 4));
        step("nest_pop_a",  1'b0, 1'b1, 1'b0, '0, '0);
        step("nest_pop_b",  1'b0, 1'b1, 1'b0, '0, '0);
        idle("nest_done");

        // Full / overflow, clear, and error-wins-over-clear
        apply_reset("reset_full");
        step("full_push1", 1'b1, 1'b0, 1'b0, mk(11, 12), '0);
        step("full_push2", 1'b1, 1'b0, 1'b0, mk(13, 14), '0);
        step("full_push3", 1'b1, 1'b0, 1'b0, mk(15, 16), '0);
        idle("full_hold");
        step("full_clear", 1'b0, 1'b0, 1'b1, '0, '0);
        step("full_err_clr", 1'b1, 1'b0, 1'b1, mk(17, 18), '0);
        idle("full_err_kept");

        // Underflow from empty
        apply_reset("reset_unf");
        step("unf_pop", 1'b0, 1'b1, 1'b0, '0, '0);
        idle("unf_hold");

        // Tail-chain at depth 1 and at full, then async reset mid-cycle
        apply_reset("reset_tail");
        step("tail_push", 1'b1, 1'b0, 1'b0, mk(7, 1), mk(5, 5));
        step("tail_chain", 1'b1, 1'b1, 1'b0, mk(99, 98), mk(6, 6));
        idle("tail_after");
        @(negedge clk);
        i_push_req = 1'b1;
        i_pop_req  = 1'b1;
        #1 i_reset = 1'b1;
        #1;
        check("async.depth",    128'(o_depth),    128'(0));
        check("async.pop_data", 128'(o_pop_data), 128'(0));
        check("async.command",  128'(o_command),  128'(C_NONE));
        check("async.ack",      128'(o_ack),      128'(0));
        check("async.empty",    128'(o_empty),    128'(1));
        m_stack.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        @(negedge clk);
        i_reset    = 1'b0;
        i_push_req = 1'b0;
        i_pop_req  = 1'b0;
        idle("async_after");

        // Full-depth tail-chain sets no flag
        step("tfull_p1", 1'b1, 1'b0, 1'b0, rnd_frame(), rnd_frame());
        step("tfull_p2", 1'b1, 1'b0, 1'b0, rnd_frame(), rnd_frame());
        step("tfull_tc", 1'b1, 1'b1, 1'b0, rnd_frame(), rnd_frame());
        idle("tfull_after");

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            logic p, q, c;
            p = ($urandom_range(0, 99) < 45);
            q = ($urandom_range(0, 99) < 40);
            c = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 79) == 0) apply_reset("rnd_reset");
            else step("rnd", p, q, c, rnd_frame(), rnd_frame());
        end
        idle("final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
